pgs_tsmac_stat_cnt_v1_2: RTL and testbench
==========================================

// Module: pgs_tsmac_stat_cnt_v1_2
// PURPOSE
//  Parametrised MAC statistics counter bank: NUM_CH independent event/byte counters, CNT_WIDTH wide,
//  read and controlled over APB. Sits beside the TSMAC core APB port. Inputs are per-channel
//  increment strobes from the RX/TX state machines. Adds atomic 64-bit reads, clear-on-read,
//  saturate/wrap mode, freeze and global clear.
// PARAMETERS
//  NUM_CH     8   number of counter channels, 1..16
//  CNT_WIDTH  64  counter width in bits, 16..64
//  INC_WIDTH  11  width of per-channel increment value (byte counts up to 2047)
// PORTS
//  pclk      in   1                  clock; all inputs synchronous to it
//  presetn   in   1                  reset, asynchronous, active-low
//  ev_vld    in   NUM_CH             per-channel increment strobe, one cycle per event
//  ev_inc    in   NUM_CH*INC_WIDTH   per-channel increment amount, ch c at [c*INC_WIDTH +: INC_WIDTH]
//  pselx     in   1                  APB select
//  penable   in   1                  APB enable
//  pwrite    in   1                  APB write
//  paddr     in   8                  APB byte address
//  pwdata    in   32                 APB write data
//  prdata    out  32                 APB read data, zero-wait
//  stat_irq  out  1                  counter overflow interrupt (level)
// BEHAVIOUR
//  Reset: all counters, hi snapshot, control regs, sticky flags = 0; prdata = 0; stat_irq = 0.
//  Access phase = pselx & penable; reads/writes take effect in that cycle; no wait states.
//  Address map: ch c low word 8*c, high word 8*c+4; CTRL 0x80; FREEZE 0x84; OVF_STS 0x88;
//   OVF_MASK 0x8C. Unmapped or ch >= NUM_CH: read 0, write ignored.
//  CTRL: bit0 SAT (1 saturate, 0 wrap); bit1 COR (clear-on-read); bit2 GCLR (self-clearing, reads 0).
//  FREEZE bit0: while 1 ev_vld ignored; counters hold.
//  Count: ev_vld[c] & !freeze -> cnt[c] += zero-extended ev_inc[c], CNT_WIDTH-bit result, 1-cycle latency
//   (APB read in the cycle after the strobe sees the new value).
//  Wrap mode: modulo 2^CNT_WIDTH. Saturate mode: sum > all-ones -> all-ones, then holds.
//  Overflow event = carry out of the add (both modes); sets sticky ovf[c].
//  Low-word read: prdata = cnt[c][31:0]; same cycle hi_snap <= cnt[c][CNT_WIDTH-1:32], zero-filled;
//   hi_snap = 0 when CNT_WIDTH <= 32.
//  High-word read of any channel returns hi_snap (software reads low then high); no side effect.
//  COR=1: low-word read clears cnt[c]; an increment in the same cycle gives cnt[c] = ev_inc[c]
//   (no event lost); hi_snap still captures the pre-clear value.
//  GCLR write: all counters and hi_snap -> 0 next cycle; same-cycle increments are dropped (clear wins).
//  Control-register writes never alter counter values except GCLR.
//  Reset mid-operation: immediate async clear of all state; no partial APB effect.
// CONFIGURATION
//  TSMAC_STAT_IRQ_EN defined:
//   - OVF_STS[NUM_CH-1:0] holds sticky ovf flags; write-1-to-clear;
//     a set in the same cycle as a clear wins.
//   - OVF_MASK[NUM_CH-1:0] is R/W, 1 = enabled.
//   - stat_irq = |(ovf & mask), registered, 1-cycle latency.
//  TSMAC_STAT_IRQ_EN undefined:
//   - No flag or mask flops; OVF_STS/OVF_MASK read 0, writes ignored.
//   - stat_irq tied 0.
// TESTING
//  1 ev_vld[0] x3, ev_inc=64 each -> ch0 low reads 192, high reads 0.
//  2 CNT_WIDTH=64, ch2 preset by 0x1_0000_0000 events' sum; read low -> 0x0000_0000, read high -> 0x1;
//    event between the two reads does not change the high value returned.
//  3 COR=1, ch1=100, read low with simultaneous ev_inc=5 -> returns 100, then reads 5.
//  4 SAT=1, CNT_WIDTH=16, cnt=0xFFF0, inc 0x20 -> 0xFFFF; SAT=0 -> 0x0010, ovf[c] set.
//  5 GCLR write with ev_vld on all ch same cycle -> all counters 0; FREEZE=1, 10 events -> unchanged.
//  6 IRQ_EN: ch3 overflow, mask[3]=1 -> stat_irq=1 one cycle later;
//    W1C OVF_STS 0x8 -> stat_irq=0; presetn low mid-count -> all reads 0.

Source files
------------

// File: rtl/pgs_tsmac_stat_cnt_v1_2.sv
// pgs_tsmac_stat_cnt_v1_2: APB statistics counter bank with hi-word snapshot, clear-on-read, saturate and global clear.
// Defining TSMAC_STAT_IRQ_EN adds sticky overflow flags, an interrupt mask and stat_irq.
module pgs_tsmac_stat_cnt_v1_2 #(
   parameter int NUM_CH    = 8,
   parameter int CNT_WIDTH = 64,
   parameter int INC_WIDTH = 11
) (
   input  logic                        pclk,
   input  logic                        presetn,
   input  logic [NUM_CH-1:0]           ev_vld,
   input  logic [NUM_CH*INC_WIDTH-1:0] ev_inc,
   input  logic                        pselx,
   input  logic                        penable,
   input  logic                        pwrite,
   input  logic [7:0]                  paddr,
   input  logic [31:0]                 pwdata,
   output logic [31:0]                 prdata,
   output logic                        stat_irq
);
   logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]        hi_snap_q, hi_snap_d;
   logic               sat_q, sat_d, cor_q, cor_d, frz_q, frz_d;
   logic [NUM_CH-1:0]  ovf_ev, inc_en;
   logic               rd, wr, ch_hit, rd_lo, gclr, unused_ok;
   logic [3:0]         ch;
   logic [CNT_WIDTH:0] sum;
   logic [63:0]        cnt_sel;
   logic [31:0]        ovf_rd, mask_rd;

   assign rd        = pselx & penable & !pwrite;
   assign wr        = pselx & penable & pwrite;
   assign ch        = paddr[6:3];
   assign ch_hit    = !paddr[7] && paddr[1:0] == 2'b00 && {28'd0, ch} < NUM_CH;
   assign rd_lo     = rd && ch_hit && !paddr[2];
   assign gclr      = wr && paddr == 8'h80 && pwdata[2];
   assign inc_en    = ev_vld & ~{NUM_CH{frz_q}};
   assign unused_ok = ^pwdata;

   // A clear-on-read low-word access restarts the add from zero so a same-cycle event is kept.
   always_comb begin
      cnt_d   = cnt_q;
      ovf_ev  = '0;
      cnt_sel = '0;
      sum     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch == 4'(c)) cnt_sel = 64'(cnt_q[c]);
         sum = (rd_lo && cor_q && ch == 4'(c) ? '0 : {1'b0, cnt_q[c]}) +
               (inc_en[c] ? (CNT_WIDTH+1)'(ev_inc[c*INC_WIDTH +: INC_WIDTH]) : '0);
         ovf_ev[c] = sum[CNT_WIDTH] & !gclr;
         cnt_d[c]  = gclr ? '0 : sum[CNT_WIDTH] && sat_q ? '1 : sum[CNT_WIDTH-1:0];
      end
      hi_snap_d = gclr ? '0 : rd_lo ? cnt_sel[63:32] : hi_snap_q;
      sat_d     = wr && paddr == 8'h80 ? pwdata[0] : sat_q;
      cor_d     = wr && paddr == 8'h80 ? pwdata[1] : cor_q;
      frz_d     = wr && paddr == 8'h84 ? pwdata[0] : frz_q;
   end

   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         cnt_q     <= '0;
         hi_snap_q <= '0;
         sat_q     <= 1'b0;
         cor_q     <= 1'b0;
         frz_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_snap_q <= hi_snap_d;
         sat_q     <= sat_d;
         cor_q     <= cor_d;
         frz_q     <= frz_d;
      end

   always_comb
      prdata = !rd ? '0 :
               ch_hit ? (paddr[2] ? hi_snap_q : cnt_sel[31:0]) :
               paddr == 8'h80 ? {30'd0, cor_q, sat_q} :
               paddr == 8'h84 ? {31'd0, frz_q} :
               paddr == 8'h88 ? ovf_rd :
               paddr == 8'h8C ? mask_rd : '0;

`ifdef TSMAC_STAT_IRQ_EN
   logic [NUM_CH-1:0] ovf_q, ovf_d, mask_q, mask_d;
   logic              irq_q, irq_d;

   // New overflow events are ORed after the W1C so a coincident set survives the clear.
   always_comb begin
      ovf_d  = (ovf_q & ~(wr && paddr == 8'h88 ? pwdata[NUM_CH-1:0] : '0)) | ovf_ev;
      mask_d = wr && paddr == 8'h8C ? pwdata[NUM_CH-1:0] : mask_q;
      irq_d  = |(ovf_q & mask_q);
   end

   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         ovf_q  <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end

   assign ovf_rd   = 32'(ovf_q);
   assign mask_rd  = 32'(mask_q);
   assign stat_irq = irq_q;
`else
   logic unused_ovf;
   assign unused_ovf = ^ovf_ev;
   assign ovf_rd     = '0;
   assign mask_rd    = '0;
   assign stat_irq   = 1'b0;
`endif
endmodule

// File: tb/tb_pgs_tsmac_stat_cnt_v1_2.sv
// tb_pgs_tsmac_stat_cnt_v1_2: directed vectors for the statistics counter bank (64-bit/8-ch and 16-bit/2-ch instances).
module tb_pgs_tsmac_stat_cnt_v1_2;
   localparam int EV = 0, WR = 1, RD = 2;
`ifdef TSMAC_STAT_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   typedef struct {
      int          kind;
      logic [7:0]  a;
      logic [31:0] d;
      logic [7:0]  v;
      logic [10:0] n;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0, presetn = 1'b0;
   logic [7:0]  ev_vld = '0;
   logic [87:0] ev_inc = '0;
   logic        pselx = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata, prdata16, r, r16;
   logic        stat_irq, stat_irq16;
   logic [7:0][63:0] pre;
   vec_t        tbl[$];
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   pgs_tsmac_stat_cnt_v1_2 dut (
      .pclk(clk), .presetn(presetn), .ev_vld(ev_vld), .ev_inc(ev_inc),
      .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .stat_irq(stat_irq));

   pgs_tsmac_stat_cnt_v1_2 #(.NUM_CH(2), .CNT_WIDTH(16)) d16 (
      .pclk(clk), .presetn(presetn), .ev_vld(ev_vld[1:0]), .ev_inc(ev_inc[21:0]),
      .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata16), .stat_irq(stat_irq16));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%h expected 0x%h", name, got, exp);
      end
   endtask

   // Starts and ends on a falling edge; events in v/n are driven during the access cycle.
   task automatic op(input int kind, input logic [7:0] a, input logic [31:0] d,
                     input logic [7:0] v, input logic [10:0] n);
      if (kind != EV) begin
         pselx = 1'b1; pwrite = (kind == WR); paddr = a; pwdata = d;
         @(negedge clk);
         penable = 1'b1;
      end
      ev_vld = v; ev_inc = {8{n}};
      #1 r = prdata; r16 = prdata16;
      @(negedge clk);
      pselx = 1'b0; penable = 1'b0; pwrite = 1'b0; ev_vld = '0;
   endtask

   task automatic add(input int kind, input logic [7:0] a, input logic [31:0] d,
                      input logic [7:0] v, input logic [10:0] n, input logic [31:0] exp);
      tbl.push_back('{kind, a, d, v, n, exp});
   endtask

   initial begin
      add(EV, 8'h00, 0, 8'h01, 64, 0);
      add(EV, 8'h00, 0, 8'h01, 64, 0);
      add(EV, 8'h00, 0, 8'h01, 64, 0);
      add(RD, 8'h00, 0, 8'h00, 0, 192);
      add(RD, 8'h04, 0, 8'h00, 0, 0);
      add(EV, 8'h00, 0, 8'hFF, 2047, 0);
      add(RD, 8'h08, 0, 8'h00, 0, 2047);
      add(RD, 8'h38, 0, 8'h00, 0, 2047);
      add(RD, 8'h40, 0, 8'h00, 0, 0);
      add(WR, 8'h40, 32'hFFFF_FFFF, 8'h00, 0, 0);
      add(WR, 8'h84, 1, 8'h00, 0, 0);
      add(RD, 8'h84, 0, 8'h00, 0, 1);
      add(EV, 8'h00, 0, 8'h01, 100, 0);
      add(RD, 8'h00, 0, 8'h00, 0, 2239);
      add(WR, 8'h84, 0, 8'h00, 0, 0);
      add(WR, 8'h80, 2, 8'h00, 0, 0);
      add(RD, 8'h80, 0, 8'h00, 0, 2);
      add(RD, 8'h08, 0, 8'h00, 0, 2047);
      add(RD, 8'h08, 0, 8'h00, 0, 0);
      add(EV, 8'h00, 0, 8'h02, 100, 0);
      add(RD, 8'h08, 0, 8'h02, 5, 100);
      add(RD, 8'h08, 0, 8'h00, 0, 5);
      add(RD, 8'h08, 0, 8'h00, 0, 0);
      add(WR, 8'h80, 0, 8'h00, 0, 0);
      add(RD, 8'h90, 0, 8'h00, 0, 0);
      add(RD, 8'h00, 0, 8'h00, 0, 2239);
      add(RD, 8'h00, 0, 8'h00, 0, 2239);
      add(WR, 8'h80, 4, 8'hFF, 7, 0);
      add(RD, 8'h80, 0, 8'h00, 0, 0);
      add(RD, 8'h00, 0, 8'h00, 0, 0);
      add(RD, 8'h38, 0, 8'h00, 0, 0);
      add(EV, 8'h00, 0, 8'h80, 1, 0);
      add(WR, 8'h80, 1, 8'h00, 0, 0);
      add(RD, 8'h38, 0, 8'h00, 0, 1);
      add(WR, 8'h80, 0, 8'h00, 0, 0);

      @(negedge clk);
      @(negedge clk);
      check("rst_prdata", prdata, 0);
      check("rst_irq", {31'd0, stat_irq}, 0);
      presetn = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         op(tbl[i].kind, tbl[i].a, tbl[i].d, tbl[i].v, tbl[i].n);
         if (tbl[i].kind == RD) check($sformatf("vec%0d", i), r, tbl[i].exp);
      end

      // Atomic 64-bit read: ch2 preloaded with 2^32.
      op(WR, 8'h80, 4, 0, 0);
      pre = '0;
      pre[2] = 64'h1_0000_0000;
      force dut.cnt_q = pre;
      #1 release dut.cnt_q;
      @(negedge clk);
      op(RD, 8'h10, 0, 0, 0);        check("snap_lo", r, 0);
      op(EV, 8'h00, 0, 8'h04, 1);
      op(RD, 8'h14, 0, 0, 0);        check("snap_hi", r, 1);
      op(RD, 8'h10, 0, 0, 0);        check("snap_lo2", r, 1);
      op(RD, 8'h00, 0, 0, 0);        check("ch0_lo", r, 0);
      op(RD, 8'h14, 0, 0, 0);        check("snap_from_ch0", r, 0);

      // Saturate / wrap on the 16-bit instance; both ch0 and ch1 reach 0xFFF0.
      op(WR, 8'h80, 4, 0, 0);
      for (int i = 0; i < 32; i++) op(EV, 8'h00, 0, 8'h03, 2047);
      op(EV, 8'h00, 0, 8'h03, 16);
      op(RD, 8'h00, 0, 0, 0);        check("fill16", r16, 32'hFFF0);
      op(WR, 8'h80, 1, 0, 0);
      op(EV, 8'h00, 0, 8'h01, 11'h20);
      op(RD, 8'h00, 0, 0, 0);        check("sat16", r16, 32'hFFFF);
                                     check("sat64", r, 32'h1_0010);
      op(EV, 8'h00, 0, 8'h01, 5);
      op(RD, 8'h00, 0, 0, 0);        check("sat16_hold", r16, 32'hFFFF);
      op(WR, 8'h80, 0, 0, 0);
      op(EV, 8'h00, 0, 8'h02, 11'h20);
      op(RD, 8'h08, 0, 0, 0);        check("wrap16", r16, 32'h10);
                                     check("nowrap64", r, 32'h1_0010);
      op(RD, 8'h04, 0, 0, 0);        check("hi16_zero", r16, 0);
      op(RD, 8'h88, 0, 0, 0);        check("ovf16", r16, IRQ ? 32'h3 : 32'h0);
                                     check("ovf64_none", r, 0);

      // Freeze blocks ten events on every channel.
      op(WR, 8'h84, 1, 0, 0);
      for (int i = 0; i < 10; i++) op(EV, 8'h00, 0, 8'hFF, 3);
      op(RD, 8'h00, 0, 0, 0);        check("frz_ch0", r, 32'h1_0015);
      op(RD, 8'h08, 0, 0, 0);        check("frz_ch1", r, 32'h1_0010);
                                     check("frz16_ch1", r16, 32'h10);
      op(WR, 8'h84, 0, 0, 0);

      // Overflow interrupt on ch3.
      op(WR, 8'h8C, 8'h08, 0, 0);
      op(RD, 8'h8C, 0, 0, 0);        check("mask_rd", r, IRQ ? 32'h8 : 32'h0);
      pre = '0;
      pre[3] = '1;
      force dut.cnt_q = pre;
      #1 release dut.cnt_q;
      @(negedge clk);
      ev_vld = 8'h08; ev_inc = {8{11'd1}};
      @(negedge clk);
      ev_vld = '0;
      check("irq_pre", {31'd0, stat_irq}, 0);
      @(negedge clk);
      check("irq_set", {31'd0, stat_irq}, {31'd0, IRQ});
      op(RD, 8'h18, 0, 0, 0);        check("ch3_wrap", r, 0);
      op(RD, 8'h88, 0, 0, 0);        check("ovf_sts", r, IRQ ? 32'h8 : 32'h0);
      op(WR, 8'h88, 8'h08, 0, 0);
      @(negedge clk);
      check("irq_clr", {31'd0, stat_irq}, 0);
      op(RD, 8'h88, 0, 0, 0);        check("ovf_w1c", r, 0);

      // Asynchronous reset in the middle of counting.
      op(WR, 8'h80, 3, 0, 0);
      op(WR, 8'h84, 1, 0, 0);
      op(WR, 8'h84, 0, 0, 0);
      ev_vld = 8'hFF; ev_inc = {8{11'd9}};
      @(negedge clk);
      #2 presetn = 1'b0;
      #1 check("rst_mid_irq", {31'd0, stat_irq}, 0);
      @(negedge clk);
      ev_vld = '0;
      presetn = 1'b1;
      @(negedge clk);
      op(RD, 8'h00, 0, 0, 0);        check("rst_ch0", r, 0);
                                     check("rst16_ch0", r16, 0);
      op(RD, 8'h38, 0, 0, 0);        check("rst_ch7", r, 0);
      op(RD, 8'h80, 0, 0, 0);        check("rst_ctrl", r, 0);
      op(RD, 8'h8C, 0, 0, 0);        check("rst_mask", r, 0);
      op(RD, 8'h14, 0, 0, 0);        check("rst_snap", r, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
